// File: rtl/imem_pkg.sv
// Shared constants and the queue entry type for the prefetching instruction memory.
package imem_pkg;

  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_ADDR_W = 11;
  localparam int IMEM_DEPTH  = 2048;

  typedef struct packed {
    logic [IMEM_ADDR_W-1:0] addr;
    logic [IMEM_DATA_W-1:0] instr;
  } imem_entry_t;

endpackage

// File: rtl/imem_fifo.sv
// Synchronous FIFO of fetched entries with a single-cycle flush that wins over push/pop.
module imem_fifo
  import imem_pkg::*;
#(
  parameter int  Q_DEPTH = 4,
  parameter type T       = imem_entry_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  T                             push_data_i,
  input  logic                         pop_i,
  output T                             head_o,
  output logic [$clog2(Q_DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(Q_DEPTH);
  localparam int CW = $clog2(Q_DEPTH+1);
  localparam logic [PW-1:0] LAST = PW'(Q_DEPTH-1);

  T              mem_q [Q_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
      if (push_i && !pop_i)      count_d = count_q + CW'(1);
      else if (!push_i && pop_i) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the head is only meaningful while count_o != 0.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/imem_prefetch.sv
// Synchronous-read instruction memory with load port, sequential fetch engine and prefetch queue.
// Output handshake: an entry transfers on a cycle where out_valid && out_ready; while out_valid && !out_ready the entry holds stable.
module imem_prefetch
  import imem_pkg::*;
#(
  parameter int DATA_W   = IMEM_DATA_W,
  parameter int ADDR_W   = IMEM_ADDR_W,
  parameter int DEPTH    = IMEM_DEPTH,
  parameter int Q_DEPTH  = 4,
  parameter int RESET_PC = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_en,
  input  logic [ADDR_W-1:0]            load_addr,
  input  logic [DATA_W-1:0]            load_data,
  input  logic                         redirect_valid,
  input  logic [ADDR_W-1:0]            redirect_addr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_instr,
  output logic [ADDR_W-1:0]            out_addr,
  output logic [$clog2(Q_DEPTH+1)-1:0] q_count
);

  localparam int CW = $clog2(Q_DEPTH+1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [CW:0]       Q_LIMIT   = (CW+1)'(Q_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              inflight_q;
  entry_t            head, hold_q, push_entry;
  logic [CW-1:0]     count;
  logic              issue, push, pop;

  // Occupancy counts the read in flight; a pop this cycle is deliberately not credited.
  assign issue = !rst && !load_en && !redirect_valid &&
                 (({1'b0, count} + {{CW{1'b0}}, inflight_q}) < Q_LIMIT);
  assign push  = inflight_q && !redirect_valid;
  assign pop   = out_valid && out_ready;

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    if (redirect_valid)
      fetch_addr_d = redirect_addr;
    else if (issue)
      fetch_addr_d = (fetch_addr_q == LAST_ADDR) ? '0 : fetch_addr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_addr_q <= ADDR_W'(RESET_PC);
      inflight_q   <= 1'b0;
      rd_addr_q    <= '0;
      hold_q       <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      inflight_q   <= issue;
      if (issue) rd_addr_q <= fetch_addr_q;
      if (pop)   hold_q    <= head;
    end
  end

  // Array and read register carry no reset; load and issue never share a cycle.
  always_ff @(posedge clk) begin
    if (load_en && ({1'b0, load_addr} < DEPTH_EXT)) mem[load_addr] <= load_data;
    if (issue) rd_data_q <= mem[fetch_addr_q];
  end

  assign push_entry = '{addr: rd_addr_q, instr: rd_data_q};

  imem_fifo #(
    .Q_DEPTH (Q_DEPTH),
    .T       (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign out_valid = (count != '0);
  assign out_instr = out_valid ? head.instr : hold_q.instr;
  assign out_addr  = out_valid ? head.addr  : hold_q.addr;
  assign q_count   = count;

endmodule

// File: tb/tb_imem_prefetch.sv
// Bench for imem_prefetch: queue-based reference model of fetch/queue/redirect/load rules.
module tb_imem_prefetch;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 11;
  localparam int DEPTH    = 2048;
  localparam int Q_DEPTH  = 4;
  localparam int RESET_PC = 0;
  localparam int CW       = $clog2(Q_DEPTH+1);
  localparam int EW       = ADDR_W + DATA_W;
  localparam int VW       = 1 + EW + CW;

  logic              clk, rst, load_en, redirect_valid, out_ready;
  logic [ADDR_W-1:0] load_addr, redirect_addr, out_addr;
  logic [DATA_W-1:0] load_data, out_instr;
  logic              out_valid;
  logic [CW-1:0]     q_count;

  imem_prefetch #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .Q_DEPTH(Q_DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_addr       (out_addr),
    .q_count        (q_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model state
  logic [EW-1:0]     exp_q[$];
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [EW-1:0]     m_fly_e, m_hold;
  bit                m_fly;
  int                m_pc;
  int                n_tests, n_fail;
  logic [VW-1:0]     got;

  function automatic logic [VW-1:0] exp_vec();
    logic [EW-1:0] h;
    h = (exp_q.size() != 0) ? exp_q[0] : m_hold;
    return {exp_q.size() != 0, h, CW'(exp_q.size())};
  endfunction

  // Advance one clock: update the model from the inputs seen at this edge, then step.
  task automatic tick();
    int sz;
    bit do_pop, do_issue;
    sz = exp_q.size();
    if (rst) begin
      exp_q.delete();
      m_fly  = 0;
      m_pc   = RESET_PC;
      m_hold = '0;
    end else begin
      do_pop   = (sz > 0) && out_ready;
      do_issue = !load_en && !redirect_valid && ((sz + int'(m_fly)) < Q_DEPTH);
      if (do_pop) m_hold = exp_q.pop_front();
      if (redirect_valid) exp_q.delete();
      else if (m_fly) exp_q.push_back(m_fly_e);
      m_fly = do_issue;
      if (do_issue) begin
        m_fly_e = {ADDR_W'(m_pc), m_mem[m_pc]};
        m_pc    = (m_pc + 1) % DEPTH;
      end
      if (redirect_valid) m_pc = int'(redirect_addr);
    end
    if (load_en && int'(load_addr) < DEPTH) m_mem[load_addr] = load_data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || q_count !== '0) begin
      n_fail++;
      $display("FAIL reset_valid_count: valid=%b count=%0d, want 0/0", out_valid, q_count);
    end
    n_tests++;
    if (out_instr !== '0 || out_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_data: instr=%h addr=%h, want 0/0", out_instr, out_addr);
    end
  endtask

  task automatic test_load_stream();
    load_en = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      load_addr = ADDR_W'(a);
      load_data = (a < 8) ? 32'h1000_0000 + a : $urandom;
      tick();
    end
    load_en   = 1'b0;
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      got = {out_valid, out_addr, out_instr, q_count};
      n_tests++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL stream cyc %0d: got %h want %h", i, got, exp_vec());
      end
      if (i < 2) begin
        n_tests++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_latency cyc %0d: valid=%b want 0", i, out_valid);
        end
      end else if (i < 10) begin
        n_tests++;
        if ({out_valid, out_addr, out_instr} !== {1'b1, ADDR_W'(i-2), 32'h1000_0000 + (i-2)}) begin
          n_fail++;
          $display("FAIL stream_seq cyc %0d: valid=%b addr=%0d instr=%h want addr=%0d", i,
                   out_valid, out_addr, out_instr, i-2);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] held;
    out_ready = 1'b0;
    held = {out_addr, out_instr};
    for (int i = 0; i < 10; i++) begin
      got = {out_valid, out_addr, out_instr, q_count};
      n_tests++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL stall cyc %0d: got %h want %h", i, got, exp_vec());
      end
      n_tests++;
      if ({out_addr, out_instr} !== held || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_stable cyc %0d: valid=%b head=%h want %h", i, out_valid,
                 {out_addr, out_instr}, held);
      end
      tick();
    end
    n_tests++;
    if (q_count !== CW'(Q_DEPTH)) begin
      n_fail++;
      $display("FAIL stall_full: count=%0d want %0d", q_count, Q_DEPTH);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      got = {out_valid, out_addr, out_instr, q_count};
      n_tests++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL resume cyc %0d: got %h want %h", i, got, exp_vec());
      end
      n_tests++;
      if (out_valid !== 1'b1 || out_addr !== ADDR_W'(int'(held[EW-1 -: ADDR_W]) + i)) begin
        n_fail++;
        $display("FAIL resume_order cyc %0d: valid=%b addr=%0d want %0d", i, out_valid,
                 out_addr, int'(held[EW-1 -: ADDR_W]) + i);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = ADDR_W'(32'h40);
    n_tests++;
    if (q_count === '0) begin
      n_fail++;
      $display("FAIL redirect_setup: count=%0d want nonzero", q_count);
    end
    tick();
    redirect_valid = 1'b0;
    for (int j = 1; j < 8; j++) begin
      got = {out_valid, out_addr, out_instr, q_count};
      n_tests++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL redirect R+%0d: got %h want %h", j, got, exp_vec());
      end
      n_tests++;
      if (j < 3 && out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL redirect_flush R+%0d: valid=%b addr=%0d want valid 0", j, out_valid, out_addr);
      end else if (j >= 3 && (out_valid !== 1'b1 || out_addr !== ADDR_W'(32'h40 + j - 3))) begin
        n_fail++;
        $display("FAIL redirect_target R+%0d: valid=%b addr=%0d want %0d", j, out_valid,
                 out_addr, 32'h40 + j - 3);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    int want;
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = ADDR_W'(DEPTH-2);
    tick();
    redirect_valid = 1'b0;
    for (int j = 1; j < 7; j++) begin
      got = {out_valid, out_addr, out_instr, q_count};
      n_tests++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap R+%0d: got %h want %h", j, got, exp_vec());
      end
      if (j >= 3) begin
        want = (DEPTH - 2 + j - 3) % DEPTH;
        n_tests++;
        if (out_valid !== 1'b1 || out_addr !== ADDR_W'(want) || out_instr !== m_mem[want]) begin
          n_fail++;
          $display("FAIL wrap_seq R+%0d: addr=%0d instr=%h want addr=%0d", j, out_addr, out_instr, want);
        end
      end
      tick();
    end
  endtask

  task automatic test_load_redirect();
    out_ready      = 1'b1;
    load_en        = 1'b1;
    load_addr      = ADDR_W'(5);
    load_data      = 32'hDEAD_BEEF;
    redirect_valid = 1'b1;
    redirect_addr  = ADDR_W'(5);
    tick();
    load_en        = 1'b0;
    redirect_valid = 1'b0;
    for (int j = 1; j < 5; j++) begin
      got = {out_valid, out_addr, out_instr, q_count};
      n_tests++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL load_redirect R+%0d: got %h want %h", j, got, exp_vec());
      end
      if (j == 3) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_addr !== ADDR_W'(5) || out_instr !== 32'hDEAD_BEEF) begin
          n_fail++;
          $display("FAIL load_redirect_word: valid=%b addr=%0d instr=%h want 5/deadbeef",
                   out_valid, out_addr, out_instr);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_addr  = ADDR_W'($urandom_range(0, DEPTH-1));
      load_en        = ($urandom_range(0, 9) == 0);
      load_addr      = ADDR_W'($urandom_range(0, DEPTH-1));
      load_data      = $urandom;
      got = {out_valid, out_addr, out_instr, q_count};
      n_tests++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h want %h", i, got, exp_vec());
      end
      tick();
    end
    load_en        = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr  = ADDR_W'(32'h100);
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() != 3; k++) begin
      got = {out_valid, out_addr, out_instr, q_count};
      n_tests++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL areset_fill %0d: got %h want %h", k, got, exp_vec());
      end
      tick();
    end
    n_tests++;
    if (q_count !== CW'(3)) begin
      n_fail++;
      $display("FAIL areset_setup: count=%0d want 3", q_count);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || q_count !== '0) begin
      n_fail++;
      $display("FAIL areset_immediate: valid=%b count=%0d want 0/0", out_valid, q_count);
    end
    tick();
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      got = {out_valid, out_addr, out_instr, q_count};
      n_tests++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL areset_restart cyc %0d: got %h want %h", i, got, exp_vec());
      end
      if (i == 2) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_addr !== ADDR_W'(RESET_PC) || out_instr !== m_mem[RESET_PC]) begin
          n_fail++;
          $display("FAIL areset_first: valid=%b addr=%0d instr=%h want addr %0d", out_valid,
                   out_addr, out_instr, RESET_PC);
        end
      end
      tick();
    end
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    load_en        = 1'b0;
    load_addr      = '0;
    load_data      = '0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    out_ready      = 1'b0;
    m_fly          = 0;
    m_fly_e        = '0;
    m_hold         = '0;
    m_pc           = RESET_PC;
    for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;

    test_reset();
    test_load_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_load_redirect();
    test_random();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
